// File: rtl/serv_bufreg_pkg.sv
// Shared types and constants for the serv_bufreg3 buffer register slice.
package serv_bufreg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    ALIGN = 3'd2,
    COUNT = 3'd3,
    DONE  = 3'd4
  } sh_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic bit legal_w(input int unsigned w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8);
  endfunction

endpackage

// File: rtl/serv_shamt_cnt.sv
// Shift-amount counter: arms from the staged operand, aligns the residual
// (amount mod W) in one beat, then counts whole W-bit shift beats.
module serv_shamt_cnt
  import serv_bufreg_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned LB = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_init,
  input  logic          i_cnt_done,
  input  logic          i_shift_op,
  input  logic [4:0]    i_shamt,
  output logic [LB-1:0] o_sh_res,
  output logic          o_sh_align,
  output logic          o_sh_done,
  output logic          o_sh_done_r
);

  sh_state_e     state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [LB-1:0] res_q, res_d;
  logic [5:0]    cnt_dec;
  logic [LB-1:0] shamt_res;
  logic          count_beat;

  assign cnt_dec    = cnt_q - 6'(W);
  assign shamt_res  = (W == 1) ? '0 : i_shamt[LB-1:0];
  assign count_beat = i_shift_op & ~i_init;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (i_en & i_init & i_cnt_done & i_shift_op) state_d = ARM;
      end
      ARM: begin
        cnt_d   = {1'b0, i_shamt};
        res_d   = shamt_res;
        state_d = (shamt_res != '0) ? ALIGN : COUNT;
      end
      ALIGN: begin
        cnt_d   = cnt_q - 6'(res_q);
        state_d = COUNT;
      end
      COUNT: begin
        if (count_beat) begin
          cnt_d = cnt_dec;
          if (cnt_dec[5]) state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Shift abandoned: drop back to idle but keep cnt/res as they were
    if ((state_q != IDLE) && !i_shift_op) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
      res_d   = res_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign o_sh_res    = (state_q == ALIGN) ? res_q : '0;
  assign o_sh_align  = (state_q == ALIGN);
  assign o_sh_done   = (state_q == COUNT) & count_beat & cnt_dec[5];
  assign o_sh_done_r = (state_q == DONE);

endmodule

// File: rtl/serv_bufreg3.sv
// Buffer register for the W-bit serial datapath: op_b select, store/load data,
// shift counting. Define SERV_BUFREG_LOADEXT_EN to build sub-word load extension.
module serv_bufreg3
  import serv_bufreg_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 4,
  parameter int unsigned LB = (BITS_PER_CYCLE > 1) ? $clog2(BITS_PER_CYCLE) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_init,
  input  logic                      i_cnt_done,
  input  logic [1:0]                i_lsb,
  input  logic                      i_byte_valid,
  input  logic                      i_op_b_sel,
  input  logic                      i_shift_op,
  input  logic                      i_right_shift_op,
  input  logic [BITS_PER_CYCLE-1:0] i_rs2,
  input  logic [BITS_PER_CYCLE-1:0] i_imm,
  input  logic                      i_load,
  input  logic [31:0]               i_dat,
  input  logic                      i_signed,
  input  logic [1:0]                i_size,
  output logic [BITS_PER_CYCLE-1:0] o_op_b,
  output logic [BITS_PER_CYCLE-1:0] o_q,
  output logic [LB-1:0]             o_sh_res,
  output logic                      o_sh_align,
  output logic                      o_sh_done,
  output logic                      o_sh_done_r,
  output logic [31:0]               o_dat
);

  localparam int unsigned W = BITS_PER_CYCLE;

  if (!legal_w(W)) begin : g_bad_w
    $error("serv_bufreg3: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  logic [31:0]  dat_q, dat_d;
  logic [W-1:0] lane;

  assign o_op_b = i_op_b_sel ? i_rs2 : i_imm;

  // Bus ack overrides any serial beat in the same cycle
  always_comb begin
    dat_d = dat_q;
    if (i_load) begin
      dat_d = i_dat;
    end else if ((i_en & (i_init | i_byte_valid)) | (i_init & i_shift_op & i_en)) begin
      dat_d = {o_op_b, dat_q[31:W]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) dat_q <= '0;
    else       dat_q <= dat_d;
  end

  assign lane  = dat_q[{i_lsb, 3'b000} +: W];
  assign o_dat = dat_q;

  serv_shamt_cnt #(
    .W  (W),
    .LB (LB)
  ) u_shamt_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_init      (i_init),
    .i_cnt_done  (i_cnt_done),
    .i_shift_op  (i_shift_op),
    .i_shamt     (dat_q[4:0]),
    .o_sh_res    (o_sh_res),
    .o_sh_align  (o_sh_align),
    .o_sh_done   (o_sh_done),
    .o_sh_done_r (o_sh_done_r)
  );

`ifdef SERV_BUFREG_LOADEXT_EN
  logic [5:0] beat_q, beat_d;
  logic       ext_q, ext_d;
  logic [4:0] msb_idx;
  logic       ext_active;
  logic       unused_in;

  assign unused_in = i_right_shift_op;

  // Item MSB position; a half-word at lane 3 wraps within the word
  assign msb_idx = (i_size == SIZE_HALF) ? ({i_lsb, 3'b000} + 5'd15) : {i_lsb, 3'b111};

  always_comb begin
    beat_d = beat_q;
    ext_d  = ext_q;
    if (i_cnt_done) begin
      beat_d = '0;
    end else if (i_en & ~i_init & (beat_q != 6'd63)) begin
      beat_d = beat_q + 6'd1;
    end
    if (i_load) ext_d = i_signed & i_dat[msb_idx];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_q <= '0;
      ext_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      ext_q  <= ext_d;
    end
  end

  assign ext_active = ((i_size == SIZE_BYTE) || (i_size == SIZE_HALF)) &&
                      ((10'(beat_q) * 10'(W)) >= (10'd8 << i_size));
  assign o_q = ext_active ? {W{ext_q}} : lane;
`else
  logic unused_in;

  assign unused_in = ^{i_right_shift_op, i_signed, i_size, SIZE_WORD};
  assign o_q       = lane;
`endif

endmodule

// File: doc/serv_bufreg3.md
# serv_bufreg3

Parametrised successor buffer register for the bit/nibble-serial SERV/QERV datapath, supporting W = 1, 2, 4 or 8 bits per cycle. It sits between the decoder/immediate path, the shifter and the memory interface. It stages op_b, holds store and load data, and counts shift amounts. It adds an explicit shift-count FSM with residual alignment for both shift directions and optional sub-word load extension.

## Interface
- BITS_PER_CYCLE, 4: W; legal values 1, 2, 4, 8.
- LB, $clog2(BITS_PER_CYCLE): residual-count width (minimum 1).
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_en  in  1  datapath beat enable.
- i_init  in  1  init phase.
- i_cnt_done  in  1  last beat of a 32-bit pass.
- i_lsb  in  2  byte lane of access.
- i_byte_valid  in  1  beat carries valid store/load lane data.
- i_op_b_sel  in  1  1 selects rs2, 0 selects imm.
- i_shift_op  in  1  shift instruction active.
- i_right_shift_op  in  1  right shift.
- i_rs2, i_imm  in  W  serial operands.
- i_load  in  1  bus ack; latch i_dat.
- i_dat  in  32  bus read data.
- i_signed  in  1  signed sub-word load.
- i_size  in  2  0 = byte, 1 = half, 2 = word.
- o_op_b  out  W  selected operand.
- o_q  out  W  lane data out.
- o_sh_res  out  LB  residual shift amount.
- o_sh_align  out  1  alignment beat active.
- o_sh_done  out  1  shift finishes this cycle.
- o_sh_done_r  out  1  registered done.
- o_dat  out  32  bus write data.

## Operation
- o_op_b = i_op_b_sel ? i_rs2 : i_imm; purely combinational.
- Data register dat[31:0]:
  - i_load has priority: dat <= i_dat.
  - Otherwise, when (i_en & (i_init | i_byte_valid)) or (i_init & i_shift_op & i_en), dat <= {o_op_b, dat[31:W]}.
  - After 32/W such beats, dat holds the full operand.
- o_q = dat[8*i_lsb +: W]. o_dat = dat.
- Shift FSM, with 6-bit cnt and LB-bit res:
  - IDLE → ARM on i_en & i_init & i_cnt_done & i_shift_op.
  - ARM, one cycle: cnt <= {0, dat[4:0]}, res <= dat[LB-1:0]. Next state is ALIGN if dat[LB-1:0] != 0, else COUNT.
  - ALIGN, one cycle: o_sh_align = 1, o_sh_res = res, cnt <= cnt − res. Applies to both left and right shifts. → COUNT.
  - COUNT: on each i_shift_op & !i_init cycle, cnt <= cnt − W. o_sh_done = bit 5 of (cnt − W). When o_sh_done = 1 → DONE. The shifter does not shift on the done cycle.
  - DONE: o_sh_done_r = 1 → IDLE when i_shift_op = 0.
- i_shift_op falling in any non-IDLE state → IDLE, with cnt and res unchanged.
- o_sh_res = 0 outside ALIGN. For W = 1, res is always 0, so ALIGN never occurs.

## Timing
- Reset values:
  - dat = 0, cnt = 0, res = 0, state = IDLE.
  - All outputs 0, except o_op_b and o_q, which follow their inputs and dat.
- Reset mid-operation aborts immediately to IDLE.
- Latency:
  - o_op_b is combinational.
  - dat update is visible the next cycle.
  - i_load data appears on o_q the cycle after the ack.
- Shift duration for amount s: 1 (ARM) + (s mod W ≠ 0 ? 1 : 0) + floor(s/W) + 1 cycles; o_sh_done is high in the last cycle.
- i_load together with i_en shifting: the load wins and the shift beat is lost.
- cnt = 0 entering COUNT: done in the first COUNT cycle.

## Configuration
- SERV_BUFREG_LOADEXT_EN defined:
  - A beat counter counts i_en & !i_init beats and clears on i_cnt_done.
  - Once beat·W ≥ 8<<i_size and i_size < 2, o_q = {W{ext}}.
  - ext = i_signed & the item MSB (dat[8*i_lsb+7] for byte, dat[8*i_lsb+15] for half), captured at i_load.
- Undefined: i_signed and i_size are ignored, o_q is raw lane data, and no beat counter is built.

## Structure
- Shared package serv_bufreg_pkg:
  - FSM state enum (IDLE, ARM, ALIGN, COUNT, DONE).
  - i_size encodings.
  - Legal-W check constant.
- Sub-module serv_shamt_cnt holds the FSM, cnt and res. The top holds dat, the muxes and the extension logic.

## Test plan
- W=4, shamt 9, right shift → ALIGN with o_sh_res=1; COUNT cnt 8→4→0; o_sh_done on 3rd COUNT cycle; o_sh_done_r the next cycle.
- W=4, shamt 0 → no ALIGN; o_sh_done in first COUNT cycle. W=8, shamt 31 → res 7; 3 shifting COUNT beats then done.
- Store W=2, rs2 stream 0xDEADBEEF, i_lsb=0 → o_dat = 0xDEADBEEF after 16 beats.
- i_load, i_dat=0x80FF_1234, i_lsb=1 → o_q = 0x2 (W=4). With LOADEXT, byte signed → o_q = 0x0 after 2 beats (dat[15]=0). Byte at lane 3, signed → 0xF after 2 beats.
- i_rst asserted in COUNT → state IDLE, o_sh_done=0, dat=0 asynchronously.
- i_shift_op dropped during ALIGN → IDLE next cycle; no o_sh_done.
